// File: rtl/rca_sum_accum.sv
// rca_sum_accum: accumulates COUNT consecutive valid sums from the pipelined
// ripple-carry adder into one block total. Totals are queued in a small result
// FIFO and presented on a valid/ready port. The input is never back-pressured.
// A total that arrives while the FIFO is full (with no pop) is dropped, and the
// drop is flagged.
//
// state  | meaning
// ACCUM  | collecting samples 1..COUNT-1 of the current block (cnt < COUNT-1)
// LAST   | next valid sample completes the block (cnt == COUNT-1)
module rca_sum_accum #(
  parameter int WIDTH      = 4,
  parameter int COUNT      = 4,
  parameter int ACC_WIDTH  = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [WIDTH:0]                sum_i,
  input  logic                          sum_valid_i,
  input  logic                          clear_i,
  output logic [ACC_WIDTH-1:0]          acc_o,
  output logic                          acc_valid_o,
  input  logic                          acc_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          drop_o,
  output logic                          overflow_o
);

  localparam int CNT_W = $clog2(COUNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ACC_WIDTH-1:0]   acc_q;

  logic [ACC_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic [ACC_WIDTH-1:0]   last_rd_q;
  logic                   overflow_q;

  logic [ACC_WIDTH-1:0]   sum_ext;
  logic [ACC_WIDTH-1:0]   total;
  logic                   blk_done;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Block completion, FIFO handshake and the drop decision for this cycle.
  always_comb begin
    sum_ext  = ACC_WIDTH'(sum_i);
    total    = acc_q + sum_ext;
    blk_done = sum_valid_i && !clear_i && (state_q == LAST);
    full     = (count_q == DEPTH_FULL);
    pop      = (count_q != '0) && acc_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO only drops when
    // nobody is reading.
    drop     = blk_done && full && !pop;
    push     = blk_done && !drop;
  end

  // Accumulator, sample counter and phase; clear restarts the block and
  // a simultaneous valid sample becomes its first sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= ACCUM;
    end else if (clear_i) begin
      if (sum_valid_i) begin
        acc_q   <= sum_ext;
        cnt_q   <= CNT_ONE;
        state_q <= (CNT_LAST == CNT_ONE) ? LAST : ACCUM;
      end else begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= ACCUM;
      end
    end else if (sum_valid_i) begin
      if (state_q == LAST) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= ACCUM;
      end else begin
        acc_q   <= total;
        cnt_q   <= cnt_q + CNT_ONE;
        state_q <= ((cnt_q + CNT_ONE) == CNT_LAST) ? LAST : ACCUM;
      end
    end
  end

  // Result FIFO storage and pointers; the last popped entry is kept so the
  // output shows it while the FIFO is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_rd_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= total;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_rd_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  // Output port drive.
  always_comb begin
    acc_valid_o  = (count_q != '0);
    acc_o        = acc_valid_o ? mem_q[rd_ptr_q] : last_rd_q;
    fifo_count_o = count_q;
    drop_o       = drop;
    overflow_o   = overflow_q;
  end

endmodule

// File: tb/tb_rca_sum_accum.sv
// Scoreboard bench for rca_sum_accum: stimulus pushes hand-computed block
// totals; a negedge monitor pops and compares on every accepted output.
module tb_rca_sum_accum;

  localparam int WIDTH      = 4;
  localparam int COUNT      = 4;
  localparam int ACC_WIDTH  = 7;
  localparam int FIFO_DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic [WIDTH:0]            sum_i = '0;
  logic                      sum_valid_i = 1'b0;
  logic                      clear_i = 1'b0;
  logic [ACC_WIDTH-1:0]      acc_o;
  logic                      acc_valid_o;
  logic                      acc_ready_i = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_o;
  logic                      drop_o;
  logic                      overflow_o;

  int errors = 0;
  int checks = 0;
  int drops_seen = 0;
  logic [ACC_WIDTH-1:0] exp_q[$];

  rca_sum_accum #(
    .WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .sum_i(sum_i), .sum_valid_i(sum_valid_i),
    .clear_i(clear_i), .acc_o(acc_o), .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i), .fifo_count_o(fifo_count_o),
    .drop_o(drop_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [WIDTH:0] s, input logic clr, input logic rdy);
    @(posedge clk);
    #1;
    sum_valid_i = v;
    sum_i       = s;
    clear_i     = clr;
    acc_ready_i = rdy;
  endtask

  task automatic send(input logic [WIDTH:0] s, input logic rdy);
    step(1'b1, s, 1'b0, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy);
  endtask

  task automatic block4(input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                        input logic [WIDTH:0] c, input logic [WIDTH:0] d, input logic rdy);
    send(a, rdy); send(b, rdy); send(c, rdy); send(d, rdy);
  endtask

  // Monitor: every accepted output must match the oldest expected total.
  always @(negedge clk) begin
    if (rstn && acc_valid_o && acc_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none", acc_o);
      end else begin
        chk("result", 32'(acc_o), 32'(exp_q.pop_front()));
      end
    end
    if (rstn && drop_o) drops_seen++;
  end

  initial begin
    #12;
    chk("rst_acc_o", 32'(acc_o), 0);
    chk("rst_valid", 32'(acc_valid_o), 0);
    chk("rst_count", 32'(fifo_count_o), 0);
    chk("rst_drop", 32'(drop_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic block with one-cycle latency check
    exp_q.push_back(7'd124);
    block4(5'd31, 5'd31, 5'd31, 5'd31, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    chk("basic_valid", 32'(acc_valid_o), 1);
    chk("basic_acc", 32'(acc_o), 124);
    chk("basic_count", 32'(fifo_count_o), 1);
    idle(1, 1'b1);
    @(negedge clk);
    chk("basic_valid_after", 32'(acc_valid_o), 0);
    chk("basic_count_after", 32'(fifo_count_o), 0);

    // Gapped input
    exp_q.push_back(7'd22);
    send(5'd5, 1'b1); idle(1, 1'b1);
    send(5'd7, 1'b1); idle(2, 1'b1);
    send(5'd1, 1'b1); send(5'd9, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    chk("gap_count", 32'(fifo_count_o), 0);

    // Backpressure and overflow
    exp_q.push_back(7'd10); exp_q.push_back(7'd20);
    exp_q.push_back(7'd30); exp_q.push_back(7'd40);
    block4(5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    block4(5'd5, 5'd5, 5'd5, 5'd5, 1'b0);
    block4(5'd6, 5'd7, 5'd8, 5'd9, 1'b0);
    block4(5'd10, 5'd10, 5'd10, 5'd10, 1'b0);
    send(5'd11, 1'b0); send(5'd12, 1'b0); send(5'd13, 1'b0);
    @(negedge clk);
    chk("ovf_count_before", 32'(fifo_count_o), 4);
    chk("ovf_no_drop_yet", 32'(drop_o), 0);
    send(5'd14, 1'b0);
    @(negedge clk);
    chk("ovf_drop", 32'(drop_o), 1);
    idle(1, 1'b0);
    @(negedge clk);
    chk("ovf_drop_pulse", 32'(drop_o), 0);
    chk("ovf_sticky", 32'(overflow_o), 1);
    chk("ovf_count", 32'(fifo_count_o), 4);
    chk("ovf_head_hold", 32'(acc_o), 10);
    idle(6, 1'b1);
    @(negedge clk);
    chk("ovf_drained", 32'(fifo_count_o), 0);
    chk("ovf_still_set", 32'(overflow_o), 1);

    // Full FIFO with push and pop in the same cycle
    exp_q.push_back(7'd4); exp_q.push_back(7'd8);
    exp_q.push_back(7'd12); exp_q.push_back(7'd16);
    exp_q.push_back(7'd20);
    block4(5'd1, 5'd1, 5'd1, 5'd1, 1'b0);
    block4(5'd2, 5'd2, 5'd2, 5'd2, 1'b0);
    block4(5'd3, 5'd3, 5'd3, 5'd3, 1'b0);
    block4(5'd4, 5'd4, 5'd4, 5'd4, 1'b0);
    send(5'd5, 1'b0); send(5'd5, 1'b0); send(5'd5, 1'b0);
    step(1'b1, 5'd5, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_pp_drop", 32'(drop_o), 0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("full_pp_count", 32'(fifo_count_o), 4);
    chk("full_pp_head", 32'(acc_o), 8);
    idle(6, 1'b1);
    @(negedge clk);
    chk("full_pp_drained", 32'(fifo_count_o), 0);

    // Clear with a simultaneous valid sample
    exp_q.push_back(7'd9);
    send(5'd3, 1'b1); send(5'd4, 1'b1);
    step(1'b1, 5'd6, 1'b1, 1'b1);
    send(5'd1, 1'b1); send(5'd1, 1'b1); send(5'd1, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    chk("clr_count", 32'(fifo_count_o), 0);
    chk("clr_overflow_kept", 32'(overflow_o), 1);

    // Asynchronous reset mid-operation
    block4(5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    block4(5'd5, 5'd5, 5'd5, 5'd5, 1'b0);
    send(5'd7, 1'b0); send(5'd7, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count_o), 2);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_acc_o", 32'(acc_o), 0);
    chk("arst_valid", 32'(acc_valid_o), 0);
    chk("arst_count", 32'(fifo_count_o), 0);
    chk("arst_drop", 32'(drop_o), 0);
    chk("arst_overflow", 32'(overflow_o), 0);
    #4;
    rstn = 1'b1;
    exp_q.push_back(7'd8);
    block4(5'd2, 5'd2, 5'd2, 5'd2, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    chk("post_rst_count", 32'(fifo_count_o), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("drop_pulses", 32'(drops_seen), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
